// File: rtl/cnn_acc_pkg.sv
// rtl/cnn_acc_pkg.sv - shared CNN accelerator types: BRAM geometry and ofmap reader FSM states
package cnn_acc_pkg;

  localparam int BRAM4K_ADDR_W = 9;
  localparam int BRAM_DATA_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ofmap_rd_state_t;

endpackage

// File: rtl/ofmap_reader_if.sv
// rtl/ofmap_reader_if.sv - ofmap output word stream (valid/ready, data, last)
interface ofmap_reader_if
  import cnn_acc_pkg::*;
#(
  parameter int DATA_W = BRAM_DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/ofmap_rd_fifo.sv
// rtl/ofmap_rd_fifo.sv - synchronous output FIFO, up to two pushes and one pop per cycle
module ofmap_rd_fifo
  import cnn_acc_pkg::*;
#(
  parameter int W     = BRAM_DATA_W + 1,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en0,
  input  logic [W-1:0] wr_data0,
  input  logic         wr_en1,
  input  logic [W-1:0] wr_data1,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         not_empty,
  output logic [PW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count_q;
  logic [PW:0]   n_wr;

  // wr_en1 is only ever raised together with wr_en0: the second word lands behind the first
  assign n_wr    = (PW+1)'(wr_en0) + (PW+1)'(wr_en1);
  assign wr_ptr1 = wr_ptr + PW'(1);

  // Storage array; no reset needed because reads are gated by not_empty
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_ptr]  <= wr_data0;
    if (wr_en1) mem[wr_ptr1] <= wr_data1;
  end

  // Pointers and occupancy; a pop frees its slot in the same cycle as a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + n_wr[PW-1:0];
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + n_wr - (PW+1)'(rd_en);
    end
  end

  assign rd_data   = mem[rd_ptr];
  assign not_empty = (count_q != '0);
  assign count     = count_q;

endmodule

// File: rtl/ofmap_reader.sv
// rtl/ofmap_reader.sv - dual-port BRAM ofmap readout into a stream; OFMAP_READER_STALL_CNT_EN adds stall_cnt
module ofmap_reader
  import cnn_acc_pkg::*;
#(
  parameter int ADDR_W     = BRAM4K_ADDR_W,
  parameter int DATA_W     = BRAM_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] dout_a,
  input  logic [DATA_W-1:0] dout_b,
  ofmap_reader_if.master    m,
  output logic              busy,
  output logic              done
`ifdef OFMAP_READER_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ofmap_rd_state_t state_q, state_d;

  logic              accept;
  logic              issue;
  logic              two;
  logic              final_issue;
  logic              can_issue;
  logic              pop;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic [RD_LAT-1:0] pv, pb, pla, plb;
  logic              push0, push1;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     iss_words;
  logic [CW-1:0]     push_words;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W:0]   fifo_rd;
  logic              fifo_ne;
  logic [CW+1:0]     need;
  logic [CW+1:0]     room;

  // rem counts words still to issue; a pair is issued whenever two or more remain
  assign two         = (rem > (ADDR_W+1)'(1));
  assign final_issue = (rem <= (ADDR_W+1)'(2));

  // Issue only if the FIFO (counting this cycle's pop) can absorb every word already in flight plus a pair
  assign need      = (CW+2)'(fifo_cnt) + (CW+2)'(inflight_q) + (CW+2)'(2);
  assign room      = (CW+2)'(FIFO_DEPTH) + (CW+2)'(pop);
  assign can_issue = (need <= room);

  assign pop = fifo_ne & m.m_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, start acceptance and read issue
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len == '0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        if (can_issue) begin
          issue = 1'b1;
          if (final_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m.m_last) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job cursor and held BRAM addresses; port B keeps its old address on a single-word issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      rem      <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else if (accept) begin
      cur_addr <= base_addr;
      rem      <= len;
    end else if (issue) begin
      cur_addr <= cur_addr + (two ? ADDR_W'(2) : ADDR_W'(1));
      rem      <= rem - (two ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
      addr_a_q <= cur_addr;
      if (two) addr_b_q <= cur_addr + ADDR_W'(1);
    end
  end

  // Addresses reach the BRAM in the issue cycle itself so the first word arrives RD_LAT+2 after start
  assign addr_a = issue ? cur_addr : addr_a_q;
  assign addr_b = (issue && two) ? (cur_addr + ADDR_W'(1)) : addr_b_q;

  // Read-latency tracker: which ports carry live data and which word ends the job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv  <= '0;
      pb  <= '0;
      pla <= '0;
      plb <= '0;
    end else begin
      pv[0]  <= issue;
      pb[0]  <= issue & two;
      pla[0] <= issue & (rem == (ADDR_W+1)'(1));
      plb[0] <= issue & (rem == (ADDR_W+1)'(2));
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pb[i]  <= pb[i-1];
        pla[i] <= pla[i-1];
        plb[i] <= plb[i-1];
      end
    end
  end

  assign push0      = pv[RD_LAT-1];
  assign push1      = pv[RD_LAT-1] & pb[RD_LAT-1];
  assign iss_words  = issue ? (two ? CW'(2) : CW'(1)) : '0;
  assign push_words = push1 ? CW'(2) : (push0 ? CW'(1) : '0);

  // Words issued to the BRAM but not yet written into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_q + iss_words - push_words;
  end

  ofmap_rd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en0    (push0),
    .wr_data0  ({pla[RD_LAT-1], dout_a}),
    .wr_en1    (push1),
    .wr_data1  ({plb[RD_LAT-1], dout_b}),
    .rd_en     (pop),
    .rd_data   (fifo_rd),
    .not_empty (fifo_ne),
    .count     (fifo_cnt)
  );

  assign m.m_valid = fifo_ne;
  assign m.m_data  = fifo_ne ? fifo_rd[DATA_W-1:0] : '0;
  assign m.m_last  = fifo_ne & fifo_rd[DATA_W];

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);

`ifdef OFMAP_READER_STALL_CNT_EN
  // Cycles a valid word waits on the consumer; cleared per job, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   stall_cnt <= '0;
    else if (accept)              stall_cnt <= '0;
    else if (m.m_valid && !m.m_ready && stall_cnt != 16'hFFFF)
                                  stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ofmap_reader.sv
// tb/tb_ofmap_reader.sv - directed job table plus reset-abort sequence for ofmap_reader
module tb_ofmap_reader;

  localparam int DATA_W = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  len = '0;
  logic [8:0]  addr_a, addr_b;
  logic [63:0] dout_a = '0, dout_b = '0;
  logic        busy, done;
`ifdef OFMAP_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  ofmap_reader_if #(.DATA_W(DATA_W)) m_if();

  ofmap_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .dout_a    (dout_a),
    .dout_b    (dout_b),
    .m         (m_if),
    .busy      (busy),
    .done      (done)
`ifdef OFMAP_READER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] word_of(input logic [8:0] a);
    return {16'hC0DE, 7'd0, a, 16'hBEEF ^ {7'd0, a}, 7'd0, a};
  endfunction

  // BRAM with one cycle read latency
  always @(posedge clk) begin
    dout_a <= word_of(addr_a);
    dout_b <= word_of(addr_b);
  end

  typedef struct {
    logic [8:0] base;
    int         len;
    int         rmode;
    int         rs_cyc;
    logic [8:0] exp_a;
    logic [8:0] exp_b;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] got_data[$];
  logic        got_last[$];
  int          xfer_cyc[$];
  int          done_n, done_cyc, busy_n, first_valid, stalls, stab_bad;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Called at a negedge; returns at a negedge once done has been seen and two more cycles passed
  task automatic run_job(input logic [8:0] b, input int l, input int rmode, input int rs_cyc);
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    got_data.delete();
    got_last.delete();
    xfer_cyc.delete();
    done_n = 0; done_cyc = -1; busy_n = 0; first_valid = -1; stalls = 0; stab_bad = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    base_addr = b;
    len = 10'(l);
    for (int c = 0; c < 2000; c++) begin
      if (c == 0) start = 1'b1;
      else if (c == rs_cyc) begin
        start = 1'b1;
        base_addr = b + 9'd280;
        len = 10'd3;
      end else start = 1'b0;
      m_if.m_ready = (rmode != 0) ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (prev_stall && (!m_if.m_valid || m_if.m_data != prev_data || m_if.m_last != prev_last))
        stab_bad++;
      prev_stall = m_if.m_valid && !m_if.m_ready;
      prev_data  = m_if.m_data;
      prev_last  = m_if.m_last;
      if (m_if.m_valid && first_valid < 0) first_valid = c;
      if (m_if.m_valid && !m_if.m_ready) stalls++;
      if (m_if.m_valid && m_if.m_ready) begin
        got_data.push_back(m_if.m_data);
        got_last.push_back(m_if.m_last);
        xfer_cyc.push_back(c);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_cyc = c;
      end
      @(negedge clk);
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    m_if.m_ready = 1'b1;
  endtask

  task automatic check_job(input string tag, input logic [8:0] b, input int l, input int rmode,
                           input logic [8:0] exp_a, input logic [8:0] exp_b);
    int bad_data, bad_last, exp_done, n;
    logic [8:0] a;
    n = got_data.size();
    bad_data = 0;
    bad_last = 0;
    for (int i = 0; i < n; i++) begin
      a = b + 9'(i);
      if (got_data[i] != word_of(a)) bad_data++;
      if (got_last[i] != (i == l - 1)) bad_last++;
    end
    chk({tag, "_count"}, n, l);
    chk({tag, "_data_bad"}, bad_data, 0);
    chk({tag, "_last_bad"}, bad_last, 0);
    chk({tag, "_done_pulses"}, done_n, 1);
    if (l == 0) exp_done = 1;
    else if (n > 0) exp_done = xfer_cyc[n-1] + 1;
    else exp_done = -2;
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_busy_cycles"}, busy_n, exp_done);
    if (l == 0) chk({tag, "_no_valid"}, first_valid, -1);
    if (rmode == 0 && l > 0) begin
      chk({tag, "_first_lat"}, first_valid, 3);
      if (n > 0) chk({tag, "_span"}, xfer_cyc[n-1] - xfer_cyc[0], l - 1);
    end
    if (rmode != 0) begin
      chk({tag, "_stable_bad"}, stab_bad, 0);
`ifdef OFMAP_READER_STALL_CNT_EN
      chk({tag, "_stall_cnt"}, longint'(stall_cnt), stalls);
`endif
    end
    chk({tag, "_addr_a"}, longint'(addr_a), longint'(exp_a));
    chk({tag, "_addr_b"}, longint'(addr_b), longint'(exp_b));
  endtask

  vec_t vecs[7];

  initial begin
    int nx, dn;
    vecs[0] = '{base: 9'd0,   len: 8,   rmode: 0, rs_cyc: -1, exp_a: 9'd6,   exp_b: 9'd7};
    vecs[1] = '{base: 9'd3,   len: 5,   rmode: 0, rs_cyc: -1, exp_a: 9'd7,   exp_b: 9'd6};
    vecs[2] = '{base: 9'd510, len: 4,   rmode: 0, rs_cyc: -1, exp_a: 9'd0,   exp_b: 9'd1};
    vecs[3] = '{base: 9'd100, len: 16,  rmode: 1, rs_cyc: -1, exp_a: 9'd114, exp_b: 9'd115};
    vecs[4] = '{base: 9'd50,  len: 0,   rmode: 0, rs_cyc: -1, exp_a: 9'd114, exp_b: 9'd115};
    vecs[5] = '{base: 9'd20,  len: 6,   rmode: 0, rs_cyc: 2,  exp_a: 9'd24,  exp_b: 9'd25};
    vecs[6] = '{base: 9'd5,   len: 512, rmode: 0, rs_cyc: -1, exp_a: 9'd3,   exp_b: 9'd4};

    m_if.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", longint'(m_if.m_valid), 0);
    chk("rst_m_last",  longint'(m_if.m_last), 0);
    chk("rst_m_data",  longint'(m_if.m_data), 0);
    chk("rst_busy",    longint'(busy), 0);
    chk("rst_done",    longint'(done), 0);
    chk("rst_addr_a",  longint'(addr_a), 0);
    chk("rst_addr_b",  longint'(addr_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int j = 0; j < 7; j++) begin
      run_job(vecs[j].base, vecs[j].len, vecs[j].rmode, vecs[j].rs_cyc);
      check_job($sformatf("job%0d", j), vecs[j].base, vecs[j].len, vecs[j].rmode,
                vecs[j].exp_a, vecs[j].exp_b);
    end

    // Abort a len=10 job after three words have gone out
    nx = 0;
    base_addr = 9'd40;
    len = 10'd10;
    m_if.m_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      start = (c == 0);
      #1;
      if (m_if.m_valid && m_if.m_ready) nx++;
      @(negedge clk);
      if (nx == 3) break;
    end
    start = 1'b0;
    chk("abort_words_before", nx, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_m_valid", longint'(m_if.m_valid), 0);
    chk("abort_m_last",  longint'(m_if.m_last), 0);
    chk("abort_m_data",  longint'(m_if.m_data), 0);
    chk("abort_busy",    longint'(busy), 0);
    chk("abort_done",    longint'(done), 0);
    chk("abort_addr_a",  longint'(addr_a), 0);
    chk("abort_addr_b",  longint'(addr_b), 0);
    dn = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (done || m_if.m_valid) dn++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (done || m_if.m_valid || busy) dn++;
    end
    chk("abort_quiet", dn, 0);
    @(negedge clk);
    run_job(9'd0, 2, 0, -1);
    check_job("post_rst", 9'd0, 2, 0, 9'd0, 9'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
